hash_checker: RTL and testbench

Sequential verifier for the hashing datapath. It accepts a message of up to 8 bytes together with an expected 32-bit hash, recomputes the hash one round per clock, and reports whether the two match. It sits on the receive side, downstream of whatever carries message and digest, and reuses the same two-lane round/mix algorithm as the combinational hasher so both ends agree bit-for-bit.

---
 rtl/hash_pkg.sv | 37 +++
 rtl/hash_round_step.sv | 19 +
 rtl/hash_checker.sv | 139 +++++++++++++
 tb/tb_hash_checker.sv | 203 ++++++++++++++++++++
 4 files changed

// File: rtl/hash_pkg.sv
// Shared constants, FSM state type and round helpers for the hasher and hash_checker.
// Both ends include this package so their round arithmetic agrees bit-for-bit.
package hash_pkg;

    localparam logic [31:0] LANE_A_INIT = 32'h55555555;
    localparam logic [31:0] LANE_B_INIT = 32'hAAAAAAAA;
    localparam int          MAX_BYTES   = 8;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    // Per-round additive constant; every round index gets a distinct value.
    function automatic logic [31:0] round_const(input logic [2:0] idx);
        logic [31:0] k;
        case (idx)
            3'd0:    k = 32'h9E3779B9;
            3'd1:    k = 32'h7F4A7C15;
            3'd2:    k = 32'hF39CC060;
            3'd3:    k = 32'h5CEDC834;
            3'd4:    k = 32'h2FF8D6A1;
            3'd5:    k = 32'hB5026F5A;
            3'd6:    k = 32'hC6EF3720;
            default: k = 32'h1B873593;
        endcase
        return k;
    endfunction

    function automatic logic [31:0] rotl32(input logic [31:0] x, input logic [4:0] amt);
        logic [63:0] doubled;
        doubled = {x, x} << amt;
        return doubled[63:32];
    endfunction

endpackage

// File: rtl/hash_round_step.sv
// One combinational round of the two-lane hash: byte mix, round-constant add, rotate.
// The rotate amount is idx*4+1, so each round index rotates by a different odd amount.
module hash_round_step
    import hash_pkg::*;
(
    input  logic [7:0]  in_byte,
    input  logic [2:0]  round_idx,
    input  logic [31:0] in_state,
    output logic [31:0] out_state
);

    logic [31:0] mixed;

    always_comb begin
        mixed     = (in_state ^ {4{in_byte}}) + round_const(round_idx);
        out_state = rotl32(mixed, {round_idx, 2'b01});
    end

endmodule

// File: rtl/hash_checker.sv
// Sequential hash verifier: one round per clock, compares the digest with the expected hash.
// Optional feature: define HASH_CHECKER_ERRCNT_EN to add a saturating mismatch counter err_count.
module hash_checker
    import hash_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [63:0] in_data,
    input  logic [3:0]  in_len,
    input  logic [31:0] in_exp_hash,
    output logic        out_valid,
    input  logic        out_ready,
    output logic        out_match,
    output logic [31:0] out_digest
`ifdef HASH_CHECKER_ERRCNT_EN
    ,
    output logic [15:0] err_count
`endif
);

    localparam logic [31:0] ZERO_DIGEST = LANE_A_INIT ^ LANE_B_INIT;

    state_t      state_q;
    logic [63:0] data_q;
    logic [3:0]  len_q;
    logic [31:0] exp_q;
    logic [31:0] lane_a_q, lane_b_q;
    logic [2:0]  idx_q;
    logic        out_valid_q, out_match_q;
    logic [31:0] out_digest_q;

    logic [3:0]  len_clamped;
    logic [63:0] data_shifted;
    logic [7:0]  cur_byte;
    logic [31:0] step_in, step_out;
    logic [31:0] lane_a_d, lane_b_d, digest_d;
    logic        last_round;

    assign len_clamped  = (in_len > 4'd8) ? 4'd8 : in_len;
    assign data_shifted = data_q >> {idx_q, 3'b000};
    assign cur_byte     = data_shifted[7:0];
    assign step_in      = idx_q[0] ? lane_b_q : lane_a_q;
    assign last_round   = ({1'b0, idx_q} == (len_q - 4'd1));

    hash_round_step u_round (
        .in_byte   (cur_byte),
        .round_idx (idx_q),
        .in_state  (step_in),
        .out_state (step_out)
    );

    // Only the lane selected by idx parity takes the round result.
    always_comb begin
        lane_a_d = lane_a_q;
        lane_b_d = lane_b_q;
        if (idx_q[0]) lane_b_d = step_out;
        else          lane_a_d = step_out;
        digest_d = lane_a_d ^ lane_b_d;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= IDLE;
            data_q       <= 64'h0;
            len_q        <= 4'h0;
            exp_q        <= 32'h0;
            lane_a_q     <= LANE_A_INIT;
            lane_b_q     <= LANE_B_INIT;
            idx_q        <= 3'd0;
            out_valid_q  <= 1'b0;
            out_match_q  <= 1'b0;
            out_digest_q <= 32'h0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (in_valid) begin
                        data_q   <= in_data;
                        len_q    <= len_clamped;
                        exp_q    <= in_exp_hash;
                        lane_a_q <= LANE_A_INIT;
                        lane_b_q <= LANE_B_INIT;
                        idx_q    <= 3'd0;
                        if (len_clamped == 4'd0) begin
                            state_q      <= DONE;
                            out_valid_q  <= 1'b1;
                            out_digest_q <= ZERO_DIGEST;
                            out_match_q  <= (in_exp_hash == ZERO_DIGEST);
                        end else begin
                            state_q <= RUN;
                        end
                    end
                end
                RUN: begin
                    lane_a_q <= lane_a_d;
                    lane_b_q <= lane_b_d;
                    idx_q    <= idx_q + 3'd1;
                    if (last_round) begin
                        state_q      <= DONE;
                        out_valid_q  <= 1'b1;
                        out_digest_q <= digest_d;
                        out_match_q  <= (digest_d == exp_q);
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        state_q     <= IDLE;
                        out_valid_q <= 1'b0;
                    end
                end
                default: begin
                    state_q     <= IDLE;
                    out_valid_q <= 1'b0;
                end
            endcase
        end
    end

    assign in_ready   = (state_q == IDLE);
    assign out_valid  = out_valid_q;
    assign out_match  = out_match_q;
    assign out_digest = out_digest_q;

`ifdef HASH_CHECKER_ERRCNT_EN
    logic [15:0] err_count_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            err_count_q <= 16'h0;
        end else if (out_valid_q && out_ready && !out_match_q && (err_count_q != 16'hFFFF)) begin
            err_count_q <= err_count_q + 16'h1;
        end
    end

    assign err_count = err_count_q;
`endif

endmodule

// File: tb/tb_hash_checker.sv
// Directed, table-driven bench for hash_checker with an independent reference hash model.
module tb_hash_checker;
    import hash_pkg::*;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [63:0] in_data = 64'h0;
    logic [3:0]  in_len = 4'h0;
    logic [31:0] in_exp_hash = 32'h0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic        out_match;
    logic [31:0] out_digest;
`ifdef HASH_CHECKER_ERRCNT_EN
    logic [15:0] err_count;
    logic [15:0] expErrCount = 16'h0;
`endif

    int totalCount = 0;
    int badCount   = 0;

    always #5 clk = ~clk;

    hash_checker dut (
        .clk         (clk),
        .reset       (reset),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .in_data     (in_data),
        .in_len      (in_len),
        .in_exp_hash (in_exp_hash),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .out_match   (out_match),
        .out_digest  (out_digest)
`ifdef HASH_CHECKER_ERRCNT_EN
        ,
        .err_count   (err_count)
`endif
    );

    typedef struct {
        logic [63:0] data;
        logic [3:0]  len;
        logic [31:0] expHash;
        logic [31:0] expDigest;
        logic        expMatch;
        int          expLatency;
    } vec_t;

    vec_t vecs[8];

    logic [31:0] kTable[8] = '{32'h9E3779B9, 32'h7F4A7C15, 32'hF39CC060, 32'h5CEDC834,
                               32'h2FF8D6A1, 32'hB5026F5A, 32'hC6EF3720, 32'h1B873593};

    // Reference round written independently: bytewise multiply-replicate and bit-serial rotate.
    function automatic logic [31:0] modelRound(input logic [31:0] lane, input logic [7:0] b, input int idx);
        logic [31:0] v;
        v = lane ^ ({24'h0, b} * 32'h01010101);
        v = v + kTable[idx];
        for (int r = 0; r < idx * 4 + 1; r++) v = {v[30:0], v[31]};
        return v;
    endfunction

    function automatic logic [31:0] modelHash(input logic [63:0] data, input logic [3:0] len);
        logic [31:0] a, b;
        int n;
        a = 32'h55555555;
        b = 32'hAAAAAAAA;
        n = (len > 4'd8) ? 8 : int'(len);
        for (int i = 0; i < n; i++) begin
            if (i % 2 == 0) a = modelRound(a, data[i*8 +: 8], i);
            else            b = modelRound(b, data[i*8 +: 8], i);
        end
        return a ^ b;
    endfunction

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        totalCount++;
        if (actual !== expected) begin
            badCount++;
            $display("[TB] FAIL %s: got %h expected %h", name, actual, expected);
        end
    endtask

    task automatic waitIdle();
        int guard = 0;
        while (!in_ready && guard < 50) begin
            @(posedge clk); #1;
            guard++;
        end
        checkOutput("idle_timeout", {31'b0, in_ready}, 32'd1);
    endtask

    task automatic completeHandshake();
`ifdef HASH_CHECKER_ERRCNT_EN
        if (!out_match && expErrCount != 16'hFFFF) expErrCount++;
`endif
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        checkOutput("ready_after_hs", {31'b0, in_ready}, 32'd1);
        checkOutput("valid_after_hs", {31'b0, out_valid}, 32'd0);
`ifdef HASH_CHECKER_ERRCNT_EN
        checkOutput("err_count", {16'b0, err_count}, {16'b0, expErrCount});
`endif
    endtask

    task automatic applyStimulus(input vec_t v);
        int cycles;
        waitIdle();
        in_data     = v.data;
        in_len      = v.len;
        in_exp_hash = v.expHash;
        in_valid    = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        cycles = 0;
        while (!out_valid && cycles < 20) begin
            @(posedge clk); #1;
            cycles++;
        end
        checkOutput("latency", cycles, v.expLatency);
        checkOutput("digest", out_digest, v.expDigest);
        checkOutput("match", {31'b0, out_match}, {31'b0, v.expMatch});
        completeHandshake();
    endtask

    initial begin
        logic [31:0] full, held;
        int cycles;

        full = modelHash(64'h0123456789ABCDEF, 4'd8);
        vecs[0] = '{64'hDEADBEEFCAFEF00D, 4'd0, 32'hFFFFFFFF, 32'hFFFFFFFF, 1'b1, 0};
        vecs[1] = '{64'h0123456789ABCDEF, 4'd8, full, full, 1'b1, 8};
        vecs[2] = '{64'h0123456789ABCDEF, 4'd8, full ^ 32'h1, full, 1'b0, 8};
        vecs[3] = '{64'h0123456789ABCDEF, 4'hF, full, full, 1'b1, 8};
        vecs[4] = '{64'h00000000000000A5, 4'd1, modelHash(64'hA5, 4'd1), modelHash(64'hA5, 4'd1), 1'b1, 1};
        vecs[5] = '{64'h1122334455667788, 4'd3, 32'h0, modelHash(64'h1122334455667788, 4'd3), 1'b0, 3};
        vecs[6] = '{64'hFFEEDDCCBBAA9988, 4'd5, modelHash(64'hFFEEDDCCBBAA9988, 4'd5),
                    modelHash(64'hFFEEDDCCBBAA9988, 4'd5), 1'b1, 5};
        vecs[7] = '{64'h0, 4'd0, 32'h0, 32'hFFFFFFFF, 1'b0, 0};
        vecs[5].expMatch = (vecs[5].expDigest == 32'h0);

        @(posedge clk); @(posedge clk); #1;
        reset = 1'b0;
        checkOutput("rst_in_ready", {31'b0, in_ready}, 32'd1);
        checkOutput("rst_out_valid", {31'b0, out_valid}, 32'd0);
        checkOutput("rst_out_match", {31'b0, out_match}, 32'd0);
        checkOutput("rst_out_digest", out_digest, 32'h0);
`ifdef HASH_CHECKER_ERRCNT_EN
        checkOutput("rst_err_count", {16'b0, err_count}, 32'h0);
`endif

        for (int i = 0; i < 8; i++) applyStimulus(vecs[i]);

        $display("[TB] backpressure sequence");
        waitIdle();
        in_data = 64'h0123456789ABCDEF; in_len = 4'd8; in_exp_hash = full; in_valid = 1'b1;
        @(posedge clk); #1;
        in_data = 64'h0; in_len = 4'd0; in_exp_hash = 32'h0;
        cycles = 0;
        while (!out_valid && cycles < 20) begin
            @(posedge clk); #1;
            cycles++;
        end
        checkOutput("bp_latency", cycles, 8);
        held = out_digest;
        for (int c = 0; c < 5; c++) begin
            @(posedge clk); #1;
            checkOutput("bp_valid", {31'b0, out_valid}, 32'd1);
            checkOutput("bp_digest", out_digest, full);
            checkOutput("bp_digest_stable", out_digest, held);
            checkOutput("bp_match", {31'b0, out_match}, 32'd1);
            checkOutput("bp_in_ready", {31'b0, in_ready}, 32'd0);
        end
        in_valid = 1'b0;
        completeHandshake();

        $display("[TB] reset mid-run sequence");
        in_data = 64'h0123456789ABCDEF; in_len = 4'd8; in_exp_hash = full; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (3) begin
            @(posedge clk); #1;
        end
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        checkOutput("midrst_out_valid", {31'b0, out_valid}, 32'd0);
        checkOutput("midrst_in_ready", {31'b0, in_ready}, 32'd1);
`ifdef HASH_CHECKER_ERRCNT_EN
        expErrCount = 16'h0;
`endif
        applyStimulus(vecs[1]);

        $display("[TB] test done: total=%0d bad=%0d", totalCount, badCount);
        $finish;
    end

endmodule
